// File: rtl/otf_sd_converter_if.sv
// Handshake/result bundle between the product digit source and the OTF converter.
// The master drives the digit stream; the converter is the slave.
interface otf_sd_converter_if #(
  parameter int N_DIGITS = 8,
  parameter int CNT_W    = 4
);
  logic                start;
  logic                digit_valid;
  logic [1:0]          digit;
  logic                busy;
  logic [CNT_W-1:0]    digit_cnt;
  logic                done;
  logic                result_valid;
  logic [N_DIGITS:0]   result;
  logic [N_DIGITS:0]   result_m;

  modport master (
    output start, digit_valid, digit,
    input  busy, digit_cnt, done, result_valid, result, result_m
  );

  modport slave (
    input  start, digit_valid, digit,
    output busy, digit_cnt, done, result_valid, result, result_m
  );
endinterface

// File: rtl/otf_sd_converter.sv
// On-the-fly conversion of an MSD-first radix-2 signed-digit stream into
// two's complement: Q and QM = Q-1 are kept so no carry chain is ever needed.
module otf_sd_converter #(
  parameter int N_DIGITS = 8,
  parameter int CNT_W    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  otf_sd_converter_if.slave         bus
);
  localparam int W = N_DIGITS + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state;
  logic [W-1:0]     q, qm;
  logic [CNT_W-1:0] cnt;
  logic             busy, done, result_valid;

  logic [W-1:0]     src_q, src_qm, nq, nqm;
  logic [CNT_W-1:0] ncnt;
  logic             accept;

  // A start clears the registers first, so a digit arriving with it lands on 0 / -1.
  always_comb begin
    src_q  = bus.start ? '0 : q;
    src_qm = bus.start ? '1 : qm;
    ncnt   = (bus.start ? '0 : cnt) + CNT_W'(1);
    accept = bus.digit_valid && (bus.start || state == ACCUM);
    nq     = {src_q[W-2:0], 1'b0};
    nqm    = {src_qm[W-2:0], 1'b1};
    case (bus.digit)
      2'b10: begin
        nq  = {src_q[W-2:0], 1'b1};
        nqm = {src_q[W-2:0], 1'b0};
      end
      2'b01: begin
        nq  = {src_qm[W-2:0], 1'b1};
        nqm = {src_qm[W-2:0], 1'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      q            <= '0;
      qm           <= '1;
      cnt          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.start) begin
        state        <= ACCUM;
        busy         <= 1'b1;
        result_valid <= 1'b0;
        q            <= src_q;
        qm           <= src_qm;
        cnt          <= '0;
      end
      if (accept) begin
        q   <= nq;
        qm  <= nqm;
        cnt <= ncnt;
        if (ncnt == CNT_W'(N_DIGITS)) begin
          state        <= HOLD;
          busy         <= 1'b0;
          done         <= 1'b1;
          result_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.busy         = busy;
  assign bus.digit_cnt    = cnt;
  assign bus.done         = done;
  assign bus.result_valid = result_valid;
  assign bus.result       = q;
  assign bus.result_m     = qm;
endmodule

// File: tb/tb_otf_sd_converter.sv
// Directed plus randomized bench for otf_sd_converter; the reference model
// accumulates the signed-digit value as a plain integer.
module tb_otf_sd_converter;
  localparam int N  = 4;
  localparam int CW = 3;
  localparam int W  = N + 1;

  localparam logic [1:0] P = 2'b10;
  localparam logic [1:0] M = 2'b01;
  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] Z11 = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  otf_sd_converter_if #(.N_DIGITS(N), .CNT_W(CW)) bus ();
  otf_sd_converter #(.N_DIGITS(N), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_val = 0;
  int m_cnt = 0;
  bit m_open = 0;
  bit m_rv = 0;
  bit m_done = 0;

  function automatic int dval(logic [1:0] d);
    return int'(d[1]) - int'(d[0]);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(bit rs, bit st, bit dv, logic [1:0] dg);
    if (!rs) begin
      m_val = 0; m_cnt = 0; m_open = 0; m_rv = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (st) begin
        m_val = 0; m_cnt = 0; m_open = 1; m_rv = 0;
      end
      if (dv && m_open) begin
        m_val = 2 * m_val + dval(dg);
        m_cnt++;
        if (m_cnt == N) begin
          m_open = 0; m_rv = 1; m_done = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [W-1:0] e_res, e_rm;
    e_res = W'(m_val);
    e_rm  = W'(m_val - 1);
    check("busy",         32'(bus.busy),         32'(m_open));
    check("digit_cnt",    32'(bus.digit_cnt),    32'(m_cnt));
    check("done",         32'(bus.done),         32'(m_done));
    check("result_valid", 32'(bus.result_valid), 32'(m_rv));
    check("result",       32'(bus.result),       32'(e_res));
    check("result_m",     32'(bus.result_m),     32'(e_rm));
  endtask

  task automatic step(bit st, bit dv, logic [1:0] dg, bit rs = 1'b1);
    @(negedge clk);
    bus.start = st; bus.digit_valid = dv; bus.digit = dg; rst_n = rs;
    @(posedge clk);
    model(rs, st, dv, dg);
    #1;
    check_all();
  endtask

  task automatic frame(logic [1:0] d1, logic [1:0] d2, logic [1:0] d3, logic [1:0] d4);
    step(1, 0, Z);
    step(0, 1, d1);
    step(0, 1, d2);
    step(0, 1, d3);
    step(0, 1, d4);
  endtask

  initial begin
    bus.start = 0; bus.digit_valid = 0; bus.digit = Z;

    step(0, 0, Z, 0);
    step(0, 1, P, 0);
    check("rst_result_m", 32'(bus.result_m), 32'(5'b11111));
    step(0, 1, P);                       // strobes in IDLE are ignored
    check("idle_cnt", 32'(bus.digit_cnt), 32'd0);

    frame(P, M, P, M);
    check("f1_done", 32'(bus.done), 32'd1);
    check("f1_res", 32'(bus.result), 32'(5'b00101));
    check("f1_rm", 32'(bus.result_m), 32'(5'b00100));
    step(0, 0, Z);
    check("f1_done_pulse", 32'(bus.done), 32'd0);

    frame(M, M, M, M);
    check("f2_res", 32'(bus.result), 32'(5'b10001));
    check("f2_rm", 32'(bus.result_m), 32'(5'b10000));
    frame(P, P, P, P);
    check("f3_res", 32'(bus.result), 32'(5'b01111));
    frame(Z11, Z, Z11, M);
    check("f4_res", 32'(bus.result), 32'(5'b11111));
    check("f4_rm", 32'(bus.result_m), 32'(5'b11110));

    step(1, 0, Z);
    step(0, 1, P);
    repeat (3) step(0, 0, Z);
    step(0, 1, Z);
    repeat (3) step(0, 0, Z);
    step(0, 1, M);
    repeat (3) step(0, 0, Z);
    step(0, 1, P);
    step(0, 1, M);
    step(0, 1, M);
    check("f5_res", 32'(bus.result), 32'(5'b00111));
    check("f5_cnt", 32'(bus.digit_cnt), 32'd4);

    step(1, 0, Z);
    step(0, 1, P);
    step(0, 1, P);
    step(1, 1, M);                       // restart with digit 1 = -1
    check("f6_cnt_restart", 32'(bus.digit_cnt), 32'd1);
    step(0, 1, Z);
    step(0, 1, Z);
    step(0, 1, P);
    check("f6_res", 32'(bus.result), 32'(5'b11001));

    step(1, 0, Z);
    step(0, 1, P);
    step(0, 1, M);
    step(0, 1, P);
    step(0, 0, Z, 0);
    check("rst_mid_res", 32'(bus.result), 32'd0);
    check("rst_mid_rv", 32'(bus.result_valid), 32'd0);
    step(0, 1, P);
    step(0, 1, M);
    check("rst_mid_ignored", 32'(bus.digit_cnt), 32'd0);

    for (int i = 0; i < 600; i++) begin
      bit st, dv, rs;
      logic [1:0] dg;
      st = ($urandom_range(0, 9) == 0) || (!m_open && $urandom_range(0, 2) == 0);
      dv = $urandom_range(0, 2) != 0;
      dg = 2'($urandom_range(0, 3));
      rs = $urandom_range(0, 59) != 0;
      step(st, dv, dg, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
